// File: rtl/hist_match_unit.sv
// hist_match_unit: L1 nearest-neighbour search over stored training histograms.
// Streams the probe histogram and each training histogram bin by bin. It sums
// |train - predict| per image and reports the closest image and its distance.
module hist_match_unit #(
  parameter int unsigned NUM_IMG = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        hist_ren_train,
  output logic [20:0] hist_addr_train,
  input  logic [7:0]  hist_rdata_train,
  output logic        hist_ren_predict,
  output logic [13:0] hist_addr_predict,
  input  logic [7:0]  hist_rdata_predict,
  output logic        busy,
  output logic        done,
  output logic [6:0]  match_id,
  output logic [23:0] min_dist
);

  localparam logic [6:0]  LastImg = 7'(NUM_IMG - 1);
  localparam logic [13:0] LastBin = 14'h3FFF;

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StCmp, StFin} state_e;

  state_e      state;
  logic [6:0]  img;
  logic [13:0] bin_cnt;
  logic [23:0] acc;
  logic [23:0] best_dist;
  logic [6:0]  best_id;
  logic        ren;
  logic        valid;  // read data on the memory ports belongs to this image
  logic [7:0]  abs_diff;
  logic        better;

  // Both memories are read in lockstep from the same bin counter.
  assign hist_ren_train    = ren;
  assign hist_ren_predict  = ren;
  assign hist_addr_predict = bin_cnt;
  assign hist_addr_train   = {img, bin_cnt};

  // Per-bin absolute difference and the strict improvement test (ties keep lower index).
  always_comb begin
    abs_diff = 8'd0;
    if (hist_rdata_train >= hist_rdata_predict) begin
      abs_diff = hist_rdata_train - hist_rdata_predict;
    end else begin
      abs_diff = hist_rdata_predict - hist_rdata_train;
    end
    better = (acc < best_dist);
  end

  // Control FSM, accumulator and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      img       <= 7'd0;
      bin_cnt   <= 14'd0;
      acc       <= 24'd0;
      best_dist <= 24'd0;
      best_id   <= 7'd0;
      ren       <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match_id  <= 7'd0;
      min_dist  <= 24'd0;
    end else begin
      // Data arrives one cycle after the read; DRAIN picks up the final bin.
      valid <= ren;
      if (valid) begin
        acc <= acc + {16'd0, abs_diff};
      end

      case (state)
        StIdle: begin
          if (enable) begin
            state     <= StRun;
            img       <= 7'd0;
            bin_cnt   <= 14'd0;
            acc       <= 24'd0;
            best_dist <= 24'hFFFFFF;
            best_id   <= 7'd0;
            ren       <= 1'b1;
            busy      <= 1'b1;
          end
        end

        StRun: begin
          if (bin_cnt == LastBin) begin
            state <= StDrain;
            ren   <= 1'b0;
          end else begin
            bin_cnt <= bin_cnt + 14'd1;
          end
        end

        StDrain: begin
          state <= StCmp;
        end

        StCmp: begin
          acc     <= 24'd0;
          bin_cnt <= 14'd0;
          if (better) begin
            best_dist <= acc;
            best_id   <= img;
          end
          if (img == LastImg) begin
            // Publish on entry to FIN so the result is valid alongside done.
            state    <= StFin;
            done     <= 1'b1;
            match_id <= better ? img : best_id;
            min_dist <= better ? acc : best_dist;
          end else begin
            img   <= img + 7'd1;
            state <= StRun;
            ren   <= 1'b1;
          end
        end

        StFin: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_match_unit.sv
// Bench for hist_match_unit: memory models, a timeline/result reference model,
// and a per-cycle compare process, with two full runs and a mid-run reset abort.
module tb_hist_match_unit;

  localparam int N       = 2;
  localparam int Bins    = 16384;
  localparam int PerImg  = 16386;
  localparam int LastCyc = N * PerImg + 1;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        hist_ren_train;
  logic [20:0] hist_addr_train;
  logic [7:0]  hist_rdata_train;
  logic        hist_ren_predict;
  logic [13:0] hist_addr_predict;
  logic [7:0]  hist_rdata_predict;
  logic        busy;
  logic        done;
  logic [6:0]  match_id;
  logic [23:0] min_dist;

  logic [7:0] train_mem [0:N*Bins-1];
  logic [7:0] pred_mem  [0:Bins-1];

  int checks = 0;
  int errors = 0;

  hist_match_unit #(.NUM_IMG(N)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .hist_ren_train     (hist_ren_train),
    .hist_addr_train    (hist_addr_train),
    .hist_rdata_train   (hist_rdata_train),
    .hist_ren_predict   (hist_ren_predict),
    .hist_addr_predict  (hist_addr_predict),
    .hist_rdata_predict (hist_rdata_predict),
    .busy               (busy),
    .done               (done),
    .match_id           (match_id),
    .min_dist           (min_dist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories; garbage is returned when not reading.
  always @(posedge clk) begin
    if (hist_ren_train) hist_rdata_train <= train_mem[hist_addr_train[14:0]];
    else                hist_rdata_train <= 8'($urandom);
    if (hist_ren_predict) hist_rdata_predict <= pred_mem[hist_addr_predict];
    else                  hist_rdata_predict <= 8'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Brute-force nearest image by L1 distance; returns {id, dist}.
  function automatic logic [30:0] model_best();
    int best_d = 32'h0100_0000;
    int best_i = 0;
    for (int k = 0; k < N; k++) begin
      int d = 0;
      for (int b = 0; b < Bins; b++) begin
        int t = int'(train_mem[k*Bins+b]);
        int p = int'(pred_mem[b]);
        d += (t > p) ? (t - p) : (p - t);
      end
      if (d < best_d) begin
        best_d = d;
        best_i = k;
      end
    end
    return {7'(best_i), 24'(best_d)};
  endfunction

  // Reference model: m_cyc is the cycle index since the accepted enable (1 = first RUN).
  logic        m_active;
  int          m_cyc;
  logic [6:0]  run_id;
  logic [23:0] run_dist;
  logic [6:0]  exp_id;
  logic [23:0] exp_dist;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_cyc    <= 0;
      exp_id   <= 7'd0;
      exp_dist <= 24'd0;
    end else if (!m_active) begin
      if (enable) begin
        m_active           <= 1'b1;
        m_cyc              <= 1;
        {run_id, run_dist} <= model_best();
      end
    end else if (m_cyc == LastCyc) begin
      m_active <= 1'b0;
      m_cyc    <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == LastCyc) begin
        exp_id   <= run_id;
        exp_dist <= run_dist;
      end
    end
  end

  int   cmp_idx;
  int   cmp_img;
  int   cmp_off;
  logic cmp_ren;
  assign cmp_idx = m_cyc - 1;
  assign cmp_img = cmp_idx / PerImg;
  assign cmp_off = cmp_idx % PerImg;
  assign cmp_ren = m_active && (m_cyc <= N * PerImg) && (cmp_off < Bins);

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_ren_train", 32'(hist_ren_train), 32'd0);
      check("rst_ren_predict", 32'(hist_ren_predict), 32'd0);
      check("rst_addr_train", 32'(hist_addr_train), 32'd0);
      check("rst_addr_predict", 32'(hist_addr_predict), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_match_id", 32'(match_id), 32'd0);
      check("rst_min_dist", 32'(min_dist), 32'd0);
    end else begin
      check("ren_train", 32'(hist_ren_train), 32'(cmp_ren));
      check("ren_predict", 32'(hist_ren_predict), 32'(cmp_ren));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_active && (m_cyc == LastCyc)));
      check("match_id", 32'(match_id), 32'(exp_id));
      check("min_dist", 32'(min_dist), 32'(exp_dist));
      if (cmp_ren) begin
        check("addr_predict", 32'(hist_addr_predict), 32'(cmp_off));
        check("addr_train", 32'(hist_addr_train), 32'(cmp_img * Bins + cmp_off));
      end
    end
  end

  // Start a run and wait (bounded) for done; optionally toggle enable during the run.
  task automatic run_once(input bit hammer, output int lat, output int rens);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    lat  = 1;
    rens = 0;
    while (!done && lat < 40000) begin
      if (hist_ren_train) rens++;
      enable = (hammer && lat < 32000) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      lat++;
    end
    enable = 1'b0;
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  int lat;
  int rens;

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    // Image 1 is the probe plus small noise; image 0 is unrelated random data.
    for (int b = 0; b < Bins; b++) begin
      int p = int'($urandom_range(4, 251));
      pred_mem[b]       = 8'(p);
      train_mem[b]      = 8'($urandom);
      train_mem[Bins+b] = 8'(p + int'($urandom_range(0, 6)) - 3);
    end
    repeat (3) @(negedge clk);
    check("reset_match_id", 32'(match_id), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_once(1'b1, lat, rens);
    check("run1_latency", 32'(lat), 32'd32773);
    check("run1_ren_cycles", 32'(rens), 32'd32768);
    check("run1_model_id", 32'(exp_id), 32'd1);
    check("run1_match_id", 32'(match_id), 32'd1);
    check("run1_min_dist", 32'(min_dist), 32'(exp_dist));
    repeat (4) @(negedge clk);
    check("run1_hold_match_id", 32'(match_id), 32'd1);

    // Start again, then abort with reset midway through image 1.
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (17000) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_min_dist", 32'(min_dist), 32'd0);
    check("abort_match_id", 32'(match_id), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Worst case: probe all zero, every training bin 255; equal distances tie.
    for (int b = 0; b < Bins; b++) begin
      pred_mem[b]       = 8'd0;
      train_mem[b]      = 8'd255;
      train_mem[Bins+b] = 8'd255;
    end
    run_once(1'b0, lat, rens);
    check("run2_latency", 32'(lat), 32'd32773);
    check("run2_ren_cycles", 32'(rens), 32'd32768);
    check("run2_model_dist", 32'(exp_dist), 32'h003F_C000);
    check("run2_min_dist", 32'(min_dist), 32'h003F_C000);
    check("run2_match_id", 32'(match_id), 32'd0);
    repeat (4) @(negedge clk);
    check("run2_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
